amber_imem_loader: RTL and testbench
====================================

# amber_imem_loader

Byte-stream program loader for the amber core's 24-bit instruction memory. It accepts a framed byte stream (sync, base address, word count, payload, XOR checksum) and assembles big-endian 24-bit instruction words. Each word is written into imem through a request/grant write port. The core is held in reset until a frame completes with a valid checksum. This lets programs be loaded through a port instead of being preloaded into imem storage.

## Interface
- ADDR_W, 12: imem word-address width; addresses wrap modulo 2^ADDR_W.
- TIMEOUT, 1024: maximum idle cycles between bytes inside a frame before an error is raised; 0 disables the timeout.
- iw_clk  in  1  clock; all state changes on the rising edge.
- iw_rst_n  in  1  asynchronous, active-low reset.
- iw_byte_valid  in  1  byte-stream valid.
- iw_byte  in  8  byte-stream data.
- ow_byte_ready  out  1  byte-stream ready; a byte is accepted on an edge where valid && ready.
- ow_imem_we  out  1  imem write request; held until granted.
- ow_imem_addr  out  ADDR_W  imem word address.
- ow_imem_wdata  out  24  imem write data.
- iw_imem_gnt  in  1  imem write grant; the write completes on an edge where we && gnt.
- ow_core_rst  out  1  active-high hold-reset for the amber core.
- ow_busy  out  1  frame in progress (HDR/DATA/CSUM states).
- ow_done  out  1  last frame loaded with a good checksum.
- ow_err  out  1  last frame failed.

## Operation
- Frame layout: 0xA5, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 3*N payload bytes (MSB first per word), then CSUM.
- CSUM = XOR of the payload bytes only.
- Base address = {ADDR_HI,ADDR_LO} truncated to ADDR_W bits. N = {CNT_HI,CNT_LO}.
- States and transitions:
  - IDLE: non-0xA5 bytes are accepted and ignored. 0xA5 -> HDR; it asserts ow_core_rst and clears done/err.
  - HDR: 4 bytes are collected.
    - N == 0 -> ERR.
    - Otherwise -> DATA, with ow_imem_addr = base, the word counter = N, and the checksum accumulator = 0.
  - DATA: a 2-bit byte index shifts bytes into the word register. On the third byte, ow_imem_wdata is loaded and ow_imem_we is set.
    - On grant: ow_imem_addr increments, wrapping to 0 after 2^ADDR_W-1, and the counter decrements.
    - When the counter reaches 0 -> CSUM.
  - CSUM: one byte is accepted.
    - Match -> DONE: done=1, core_rst=0.
    - Mismatch -> ERR: err=1, core_rst stays 1.
  - DONE and ERR behave like IDLE: they keep scanning for 0xA5, and 0xA5 restarts a frame.
- Backpressure: ow_byte_ready = !ow_imem_we. All other states accept a byte every cycle.
- Timeout: an idle counter runs in HDR, DATA and CSUM. It resets on every accepted byte and also on every cycle where ow_imem_we is high.
  - When it reaches TIMEOUT -> ERR. Any partial word is discarded and no write is issued.
- Inside HDR, DATA and CSUM, 0xA5 is ordinary data with no resync.
- Reset mid-frame: every register returns to its reset value immediately (asynchronously). A pending write request is dropped.

## Timing
- Reset values: ow_byte_ready=1, ow_imem_we=0, ow_imem_addr=0, ow_imem_wdata=0, ow_core_rst=1, ow_busy=0, ow_done=0, ow_err=0. State = IDLE.
- Write issue: third byte of a word accepted at edge k -> ow_imem_we=1 and ow_byte_ready=0 from k+1.
- Write completion: with gnt held high, the write completes at edge k+1, and we=0, ready=1 from k+2. Minimum cost is 4 cycles per word.
- Each word is written exactly once, on the single edge with we && gnt.
- Last write: the final word's write completes before CSUM can be accepted, because ready is low until then.
- CSUM accepted at edge c -> ow_done (or ow_err) and ow_core_rst update at c+1. ow_busy falls at c+1.
- ow_busy rises the cycle after 0xA5 is accepted.

## Test plan
- Load at base 0x000, N=5, payload 30 10 00 72 10 03 30 20 01 30 30 02 A0 00 00, CSUM 0xF2, gnt tied 1 -> mem[0..4] = 301000, 721003, 302001, 303002, A00000; done=1, core_rst=0, exactly 5 we pulses.
- Same frame but CSUM 0xF3 -> all 5 writes occur, then err=1, done=0, core_rst=1. A following good frame -> done=1.
- Base 0xFFE, N=3, with gnt delayed 3 cycles per write -> writes go to 0xFFE, 0xFFF, 0x000; ready stays low while each request waits; no byte is lost.
- Bytes 00 FF 12 before 0xA5 -> ignored, no writes. A header with N=0 -> err=1 one cycle after CNT_LO.
- TIMEOUT=16, stall after 2 of 3 payload bytes -> err=1 exactly 16 cycles after the last byte; no write issued.
- Assert iw_rst_n=0 mid-DATA while we=1 -> outputs take their reset values immediately. A new full frame then loads correctly.

Source files
------------

// File: rtl/amber_imem_loader.sv
// rtl/amber_imem_loader.sv - framed byte-stream loader that writes 24-bit words into amber imem
module amber_imem_loader #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 1024
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_byte_valid,
    input  logic [7:0]        iw_byte,
    output logic              ow_byte_ready,
    output logic              ow_imem_we,
    output logic [ADDR_W-1:0] ow_imem_addr,
    output logic [23:0]       ow_imem_wdata,
    input  logic              iw_imem_gnt,
    output logic              ow_core_rst,
    output logic              ow_busy,
    output logic              ow_done,
    output logic              ow_err
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [1:0]        idx, idx_nx;
    logic [23:0]       shreg, shreg_nx;
    logic [15:0]       cnt, cnt_nx;
    logic [7:0]        csum, csum_nx;
    logic [TW-1:0]     idle, idle_nx;
    logic              we_nx, core_rst_nx, done_nx, err_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [23:0]       wdata_nx;
    logic              accept;
    logic              timeout_hit;
    logic [15:0]       hdr_base;
    logic [15:0]       hdr_cnt;

    assign ow_byte_ready = !ow_imem_we;
    assign accept        = iw_byte_valid && ow_byte_ready;
    assign ow_busy       = state inside {S_HDR, S_DATA, S_CSUM};
    // The shift register holds ADDR_HI, ADDR_LO, CNT_HI when CNT_LO arrives.
    assign hdr_base      = shreg[23:8];
    assign hdr_cnt       = {shreg[7:0], iw_byte};
    assign timeout_hit   = (TIMEOUT != 0) && !accept && !ow_imem_we
                           && (idle == TW'(TIMEOUT - 1));

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state         <= S_IDLE;
            idx           <= '0;
            shreg         <= '0;
            cnt           <= '0;
            csum          <= '0;
            idle          <= '0;
            ow_imem_we    <= 1'b0;
            ow_imem_addr  <= '0;
            ow_imem_wdata <= '0;
            ow_core_rst   <= 1'b1;
            ow_done       <= 1'b0;
            ow_err        <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            shreg         <= shreg_nx;
            cnt           <= cnt_nx;
            csum          <= csum_nx;
            idle          <= idle_nx;
            ow_imem_we    <= we_nx;
            ow_imem_addr  <= addr_nx;
            ow_imem_wdata <= wdata_nx;
            ow_core_rst   <= core_rst_nx;
            ow_done       <= done_nx;
            ow_err        <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        shreg_nx    = shreg;
        cnt_nx      = cnt;
        csum_nx     = csum;
        idle_nx     = (accept || ow_imem_we) ? '0 : idle + 1'b1;
        we_nx       = ow_imem_we;
        addr_nx     = ow_imem_addr;
        wdata_nx    = ow_imem_wdata;
        core_rst_nx = ow_core_rst;
        done_nx     = ow_done;
        err_nx      = ow_err;

        case (state)
            S_HDR: begin
                if (accept) begin
                    shreg_nx = {shreg[15:0], iw_byte};
                    idx_nx   = idx + 1'b1;
                    if (idx == 2'd3) begin
                        idx_nx = '0;
                        if (hdr_cnt == 16'd0) begin
                            state_nx = S_ERR;
                            err_nx   = 1'b1;
                        end else begin
                            state_nx = S_DATA;
                            addr_nx  = ADDR_W'(hdr_base);
                            cnt_nx   = hdr_cnt;
                            csum_nx  = '0;
                        end
                    end
                end else if (timeout_hit) begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end
            end
            S_DATA: begin
                if (ow_imem_we) begin
                    if (iw_imem_gnt) begin
                        we_nx   = 1'b0;
                        addr_nx = ow_imem_addr + 1'b1;
                        cnt_nx  = cnt - 1'b1;
                        if (cnt == 16'd1)
                            state_nx = S_CSUM;
                    end
                end else if (accept) begin
                    csum_nx  = csum ^ iw_byte;
                    shreg_nx = {shreg[15:0], iw_byte};
                    if (idx == 2'd2) begin
                        idx_nx   = '0;
                        wdata_nx = {shreg[15:0], iw_byte};
                        we_nx    = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else if (timeout_hit) begin
                    // A partial word is simply dropped.
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                    idx_nx   = '0;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (iw_byte == csum) begin
                        state_nx    = S_DONE;
                        done_nx     = 1'b1;
                        core_rst_nx = 1'b0;
                    end else begin
                        state_nx = S_ERR;
                        err_nx   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end
            end
            default: begin
                idle_nx = '0;
                if (accept && iw_byte == 8'hA5) begin
                    state_nx    = S_HDR;
                    idx_nx      = '0;
                    core_rst_nx = 1'b1;
                    done_nx     = 1'b0;
                    err_nx      = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_amber_imem_loader.sv
// tb/tb_amber_imem_loader.sv - self-checking bench for amber_imem_loader
module tb_amber_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  bt = 8'h00;
    logic        gnt = 1'b1;
    logic        ready, we, core_rst, busy, done, err;
    logic [11:0] addr;
    logic [23:0] wdata;

    int n_vec = 0;
    int n_fail = 0;
    int gnt_delay = 0;
    int wr_count = 0;
    int wait_cycles = 0;
    int wr0;

    logic [23:0] tb_mem [0:4095];
    logic [35:0] exp_q [$];
    logic [7:0]  pl [$];

    always #5 clk = ~clk;

    amber_imem_loader #(.ADDR_W(12), .TIMEOUT(16)) dut (
        .iw_clk        (clk),
        .iw_rst_n      (rst_n),
        .iw_byte_valid (valid),
        .iw_byte       (bt),
        .ow_byte_ready (ready),
        .ow_imem_we    (we),
        .ow_imem_addr  (addr),
        .ow_imem_wdata (wdata),
        .iw_imem_gnt   (gnt),
        .ow_core_rst   (core_rst),
        .ow_busy       (busy),
        .ow_done       (done),
        .ow_err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // grant responder: grant after gnt_delay waiting cycles, or always when 0
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gnt_delay == 0) gnt = 1'b1;
            else if (!we) begin c = 0; gnt = 1'b0; end
            else if (c >= gnt_delay) gnt = 1'b1;
            else begin c++; gnt = 1'b0; end
        end
    end

    // compare process: every write against the model's expected word stream
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("ready_vs_we", ready, !we);
                if (we && !gnt) wait_cycles++;
                if (we && gnt) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr, wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", addr, e[35:24]);
                        chk("wr_data", wdata, e[23:0]);
                    end
                    tb_mem[addr] = wdata;
                    wr_count++;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int t;
        acc = 0;
        t = 0;
        valid = 1'b1;
        bt = b;
        do begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            t++;
        end while (!acc && t < 200);
        #1;
        valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL byte_accept: byte %0h got no acceptance expected acceptance within 200 cycles", b);
        end
    endtask

    // model: words are consecutive payload triples at base+i mod 4096, csum is XOR of payload
    task automatic send_frame(input logic [15:0] base, input bit bad);
        logic [7:0]  cs;
        logic [11:0] a;
        int          n;
        cs = 8'h00;
        n = pl.size() / 3;
        for (int i = 0; i < pl.size(); i++) cs ^= pl[i];
        for (int w = 0; w < n; w++) begin
            a = base[11:0] + 12'(w);
            exp_q.push_back({a, pl[3*w], pl[3*w+1], pl[3*w+2]});
        end
        send_byte(8'hA5);
        send_byte(base[15:8]);
        send_byte(base[7:0]);
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < pl.size(); i++) send_byte(pl[i]);
        send_byte(bad ? (cs ^ 8'h01) : cs);
        chk("all_writes_done", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        #12;
        chk_reset_vals("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // good frame at base 0
        pl = '{8'h30, 8'h10, 8'h00, 8'h72, 8'h10, 8'h03, 8'h30, 8'h20, 8'h01,
               8'h30, 8'h30, 8'h02, 8'hA0, 8'h00, 8'h00};
        wr0 = wr_count;
        send_frame(16'h0000, 0);
        chk("t1_done", done, 1);
        chk("t1_err", err, 0);
        chk("t1_core_rst", core_rst, 0);
        chk("t1_busy", busy, 0);
        chk("t1_writes", wr_count - wr0, 5);
        chk("t1_mem0", tb_mem[0], 24'h301000);
        chk("t1_mem1", tb_mem[1], 24'h721003);
        chk("t1_mem2", tb_mem[2], 24'h302001);
        chk("t1_mem3", tb_mem[3], 24'h303002);
        chk("t1_mem4", tb_mem[4], 24'hA00000);

        // same frame with checksum F3, then a good one
        wr0 = wr_count;
        send_frame(16'h0000, 1);
        chk("t2_err", err, 1);
        chk("t2_done", done, 0);
        chk("t2_core_rst", core_rst, 1);
        chk("t2_writes", wr_count - wr0, 5);
        send_frame(16'h0000, 0);
        chk("t2_redo_done", done, 1);
        chk("t2_redo_err", err, 0);

        // wrap at top of imem with delayed grants
        gnt_delay = 3;
        wait_cycles = 0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        send_frame(16'h0FFE, 0);
        chk("t3_memffe", tb_mem[12'hFFE], 24'h112233);
        chk("t3_memfff", tb_mem[12'hFFF], 24'h445566);
        chk("t3_mem000", tb_mem[12'h000], 24'h778899);
        chk("t3_wait_cycles", wait_cycles, 9);
        chk("t3_done", done, 1);
        gnt_delay = 0;

        // junk before sync, then a zero-count header
        wr0 = wr_count;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        chk("t4_junk_done", done, 1);
        chk("t4_junk_busy", busy, 0);
        chk("t4_junk_writes", wr_count - wr0, 0);
        send_byte(8'hA5);
        chk("t4_sync_busy", busy, 1);
        chk("t4_sync_core_rst", core_rst, 1);
        chk("t4_sync_done", done, 0);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t4_hdr_err", err, 0);
        send_byte(8'h00);
        chk("t4_n0_err", err, 1);
        chk("t4_n0_busy", busy, 0);

        // stall two bytes into a word
        wr0 = wr_count;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAB);
        send_byte(8'hCD);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
        end
        chk("t5_not_early_err", err, 0);
        chk("t5_not_early_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("t5_timeout_err", err, 1);
        chk("t5_timeout_busy", busy, 0);
        chk("t5_core_rst", core_rst, 1);
        chk("t5_writes", wr_count - wr0, 0);

        // reset while a write is pending
        gnt_delay = 1000;
        wr0 = wr_count;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        chk("t6_we_pending", we, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt_delay = 0;
        @(posedge clk);
        #1;
        chk("t6_dropped_writes", wr_count - wr0, 0);
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h42};
        send_frame(16'h0100, 0);
        chk("t6_mem100", tb_mem[12'h100], 24'hDEADBE);
        chk("t6_mem101", tb_mem[12'h101], 24'hEF0042);
        chk("t6_done", done, 1);
        chk("t6_core_rst", core_rst, 0);
        chk("t6_writes", wr_count - wr0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
